// File: rtl/wb_pkg.sv
// Shared types and sizes for the write-back stage.
// Holds the write-back FSM state encoding and the default datapath widths.
package wb_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_AW   = 4;
  localparam int NUM_REGS = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    WAIT_LD = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_stage_writer.sv
// Purpose: write-back stage; holds one retiring instruction and drives the register-file write port.
// Latency: accept at posedge N -> wb_en high in cycle N+1; loads write the cycle after ld_valid is sampled.
// Backpressure: mem_ready drops only while a load waits for its data; otherwise 1 instruction/cycle.
// Ports: clk/rst (async, active-high); mem_* instruction handshake from MEM; ld_valid/ld_data/ld_ready
//   load-data return; wb_en/wb_dest/wb_value register-file write port; retire_count retired instructions.
// Optional: WB_FORWARD_EN adds fwd_valid/fwd_dest/fwd_value so ID can bypass the same-cycle write.
module wb_stage_writer #(
  parameter int DATA_W = wb_pkg::DATA_W,
  parameter int REG_AW = wb_pkg::REG_AW,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic              mem_wb_en,
  input  logic              mem_r_en,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_dest,
  output logic [DATA_W-1:0] wb_value,
  output logic [CNT_W-1:0]  retire_count
`ifdef WB_FORWARD_EN
  ,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_dest,
  output logic [DATA_W-1:0] fwd_value
`endif
);
  import wb_pkg::*;

  wb_state_t         state, state_nxt;
  logic              h_wb_en, h_wb_en_nxt;
  logic [REG_AW-1:0] h_dest, h_dest_nxt;
  logic [DATA_W-1:0] h_value, h_value_nxt;
  logic [CNT_W-1:0]  cnt;

  always_comb begin
    state_nxt   = state;
    h_wb_en_nxt = h_wb_en;
    h_dest_nxt  = h_dest;
    h_value_nxt = h_value;
    case (state)
      IDLE, WRITE: begin
        if (mem_valid) begin
          // Destination and enable are latched even for a load that must wait,
          // so the write port already points at the pending register.
          h_wb_en_nxt = mem_wb_en;
          h_dest_nxt  = mem_dest;
          if (!mem_r_en) begin
            h_value_nxt = mem_alu_result;
            state_nxt   = WRITE;
          end else if (ld_valid) begin
            h_value_nxt = ld_data;
            state_nxt   = WRITE;
          end else begin
            state_nxt   = WAIT_LD;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT_LD: begin
        // Loads with mem_wb_en=0 still wait here so the memory response is consumed.
        if (ld_valid) begin
          h_value_nxt = ld_data;
          state_nxt   = WRITE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      h_wb_en <= 1'b0;
      h_dest  <= '0;
      h_value <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      h_wb_en <= h_wb_en_nxt;
      h_dest  <= h_dest_nxt;
      h_value <= h_value_nxt;
      // Every cycle spent in WRITE is a distinct retirement, including back-to-back ones.
      if (state_nxt == WRITE) cnt <= cnt + CNT_W'(1);
    end
  end

  assign mem_ready    = (state != WAIT_LD);
  assign ld_ready     = (state == WAIT_LD);
  assign wb_en        = (state == WRITE) && h_wb_en;
  assign wb_dest      = h_dest;
  assign wb_value     = h_value;
  assign retire_count = cnt;

`ifdef WB_FORWARD_EN
  assign fwd_valid = wb_en;
  assign fwd_dest  = h_dest;
  assign fwd_value = h_value;
`endif

endmodule

// File: tb/tb_wb_stage_writer.sv
// Bench for wb_stage_writer: directed scenarios followed by a randomized instruction stream
// checked against a transaction-level model (one expected write per retired instruction).
module tb_wb_stage_writer;

  logic        clk, rst;
  logic        mem_valid, mem_ready, mem_wb_en, mem_r_en;
  logic [3:0]  mem_dest;
  logic [31:0] mem_alu_result;
  logic        ld_valid, ld_ready;
  logic [31:0] ld_data;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;
  logic [31:0] retire_count;
`ifdef WB_FORWARD_EN
  logic        fwd_valid;
  logic [3:0]  fwd_dest;
  logic [31:0] fwd_value;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_count;

  wb_stage_writer dut (
    .clk            (clk),
    .rst            (rst),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_wb_en      (mem_wb_en),
    .mem_r_en       (mem_r_en),
    .mem_dest       (mem_dest),
    .mem_alu_result (mem_alu_result),
    .ld_valid       (ld_valid),
    .ld_data        (ld_data),
    .ld_ready       (ld_ready),
    .wb_en          (wb_en),
    .wb_dest        (wb_dest),
    .wb_value       (wb_value),
    .retire_count   (retire_count)
`ifdef WB_FORWARD_EN
    ,
    .fwd_valid      (fwd_valid),
    .fwd_dest       (fwd_dest),
    .fwd_value      (fwd_value)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    mem_valid = 1'b0; mem_wb_en = 1'b0; mem_r_en = 1'b0;
    mem_dest = 4'd0; mem_alu_result = 32'd0;
    ld_valid = 1'b0; ld_data = 32'd0;
  endtask

  task automatic present(input logic wen, input logic ren, input logic [3:0] dst, input logic [31:0] alu);
    mem_valid = 1'b1; mem_wb_en = wen; mem_r_en = ren; mem_dest = dst; mem_alu_result = alu;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    quiet();
    #12;
    n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL reset_wb_en: got %b want 0", wb_en); end
    n_cmp++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL reset_mem_ready: got %b want 1", mem_ready); end
    n_cmp++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL reset_ld_ready: got %b want 0", ld_ready); end
    n_cmp++; if (retire_count !== 32'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", retire_count); end
    n_cmp++; if (wb_dest !== 4'd0 || wb_value !== 32'd0)
      begin n_err++; $display("FAIL reset_hold: got dest %0d value %h want 0/0", wb_dest, wb_value); end
    rst = 1'b0;
    exp_count = 32'd0;
  endtask

  task automatic test_back_to_back();
    present(1'b1, 1'b0, 4'd3, 32'h11);
    step();
    present(1'b1, 1'b0, 4'd4, 32'h22);
    n_cmp++; if (wb_en !== 1'b1 || wb_dest !== 4'd3 || wb_value !== 32'h11)
      begin n_err++; $display("FAIL b2b_first: got en %b dest %0d val %h want 1/3/11", wb_en, wb_dest, wb_value); end
    step();
    quiet();
    n_cmp++; if (wb_en !== 1'b1 || wb_dest !== 4'd4 || wb_value !== 32'h22)
      begin n_err++; $display("FAIL b2b_second: got en %b dest %0d val %h want 1/4/22", wb_en, wb_dest, wb_value); end
    exp_count = exp_count + 32'd2;
    n_cmp++; if (retire_count !== exp_count) begin n_err++; $display("FAIL b2b_count: got %0d want %0d", retire_count, exp_count); end
    step();
    n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got en %b want 0", wb_en); end
  endtask

  task automatic test_load_wait();
    int hi_cycles = 0;
    present(1'b1, 1'b1, 4'd5, 32'hBAD0BAD0);
    step();
    quiet();
    for (int k = 1; k <= 3; k++) begin
      if (mem_ready === 1'b0 && ld_ready === 1'b1 && wb_en === 1'b0) hi_cycles++;
      if (k == 3) begin ld_valid = 1'b1; ld_data = 32'hDEADBEEF; end
      step();
    end
    ld_valid = 1'b0;
    n_cmp++; if (hi_cycles != 3) begin n_err++; $display("FAIL ldw_stall: got %0d waiting cycles want 3", hi_cycles); end
    n_cmp++; if (wb_en !== 1'b1 || wb_dest !== 4'd5 || wb_value !== 32'hDEADBEEF)
      begin n_err++; $display("FAIL ldw_write: got en %b dest %0d val %h want 1/5/deadbeef", wb_en, wb_dest, wb_value); end
    n_cmp++; if (mem_ready !== 1'b1 || ld_ready !== 1'b0)
      begin n_err++; $display("FAIL ldw_ready: got mem_ready %b ld_ready %b want 1/0", mem_ready, ld_ready); end
    exp_count = exp_count + 32'd1;
    step();
    n_cmp++; if (wb_en !== 1'b0 || retire_count !== exp_count)
      begin n_err++; $display("FAIL ldw_after: got en %b count %0d want 0/%0d", wb_en, retire_count, exp_count); end
  endtask

  task automatic test_load_same_cycle();
    present(1'b1, 1'b1, 4'd6, 32'h99);
    ld_valid = 1'b1; ld_data = 32'h7;
    step();
    quiet();
    exp_count = exp_count + 32'd1;
    n_cmp++; if (wb_en !== 1'b1 || wb_dest !== 4'd6 || wb_value !== 32'h7 || ld_ready !== 1'b0)
      begin n_err++; $display("FAIL ldsame: got en %b dest %0d val %h ld_ready %b want 1/6/7/0", wb_en, wb_dest, wb_value, ld_ready); end
    n_cmp++; if (retire_count !== exp_count) begin n_err++; $display("FAIL ldsame_count: got %0d want %0d", retire_count, exp_count); end
    step();
  endtask

  task automatic test_no_wb_en();
    present(1'b0, 1'b0, 4'd9, 32'h55);
    step();
    quiet();
    exp_count = exp_count + 32'd1;
    n_cmp++; if (wb_en !== 1'b0 || retire_count !== exp_count)
      begin n_err++; $display("FAIL nowb_alu: got en %b count %0d want 0/%0d", wb_en, retire_count, exp_count); end
    ld_valid = 1'b1; ld_data = 32'hAAAA5555;
    step();
    ld_valid = 1'b0;
    n_cmp++; if (wb_en !== 1'b0 || ld_ready !== 1'b0 || retire_count !== exp_count || wb_value !== 32'h55)
      begin n_err++; $display("FAIL nowb_stray_ld: got en %b ld_ready %b count %0d val %h want 0/0/%0d/55", wb_en, ld_ready, retire_count, wb_value, exp_count); end
    present(1'b0, 1'b1, 4'd10, 32'h0);
    step();
    quiet();
    n_cmp++; if (ld_ready !== 1'b1 || mem_ready !== 1'b0)
      begin n_err++; $display("FAIL nowb_ld_wait: got ld_ready %b mem_ready %b want 1/0", ld_ready, mem_ready); end
    ld_valid = 1'b1; ld_data = 32'h1234;
    step();
    ld_valid = 1'b0;
    exp_count = exp_count + 32'd1;
    n_cmp++; if (wb_en !== 1'b0 || retire_count !== exp_count || ld_ready !== 1'b0)
      begin n_err++; $display("FAIL nowb_ld_retire: got en %b count %0d ld_ready %b want 0/%0d/0", wb_en, retire_count, ld_ready, exp_count); end
    step();
  endtask

  task automatic test_reset_mid_stream();
    present(1'b1, 1'b0, 4'd2, 32'hCAFE);
    step();
    quiet();
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (wb_en !== 1'b0 || mem_ready !== 1'b1 || ld_ready !== 1'b0 || retire_count !== 32'd0)
      begin n_err++; $display("FAIL arst_write: got en %b mr %b lr %b count %0d want 0/1/0/0", wb_en, mem_ready, ld_ready, retire_count); end
    #1 rst = 1'b0;
    present(1'b1, 1'b1, 4'd7, 32'h0);
    step();
    quiet();
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (wb_en !== 1'b0 || mem_ready !== 1'b1 || ld_ready !== 1'b0 || retire_count !== 32'd0)
      begin n_err++; $display("FAIL arst_waitld: got en %b mr %b lr %b count %0d want 0/1/0/0", wb_en, mem_ready, ld_ready, retire_count); end
    #1 rst = 1'b0;
    exp_count = 32'd0;
    ld_valid = 1'b1; ld_data = 32'hFEEDFACE;
    step();
    ld_valid = 1'b0;
    n_cmp++; if (wb_en !== 1'b0 || retire_count !== 32'd0 || wb_value === 32'hFEEDFACE)
      begin n_err++; $display("FAIL arst_late_ld: got en %b count %0d val %h want no write", wb_en, retire_count, wb_value); end
  endtask

  // Randomized stream: each instruction has a random gap, type, enable and load latency.
  // The model predicts one write per instruction, in the cycle after its data is available.
  task automatic test_random();
    logic        wen, ren;
    logic [3:0]  dst;
    logic [31:0] alu, data, exp_val;
    int          lat;
    for (int i = 0; i < 300; i++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        quiet();
        ld_valid = 1'($urandom_range(0, 1)); ld_data = $urandom;
        step();
        n_cmp++; if (wb_en !== 1'b0 || mem_ready !== 1'b1 || retire_count !== exp_count)
          begin n_err++; $display("FAIL rnd_gap[%0d]: got en %b mr %b count %0d want 0/1/%0d", i, wb_en, mem_ready, retire_count, exp_count); end
      end
      wen = 1'($urandom_range(0, 1));
      ren = 1'($urandom_range(0, 1));
      dst = 4'($urandom);
      alu = $urandom;
      data = $urandom;
      lat = ren ? $urandom_range(0, 3) : 0;
      exp_val = ren ? data : alu;
      quiet();
      present(wen, ren, dst, alu);
      if (ren && lat == 0) begin ld_valid = 1'b1; ld_data = data; end
      else if (!ren) begin ld_valid = 1'($urandom_range(0, 1)); ld_data = ~data; end
      n_cmp++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL rnd_accept[%0d]: got mem_ready %b want 1", i, mem_ready); end
      step();
      quiet();
      for (int k = 1; k <= lat; k++) begin
        n_cmp++; if (mem_ready !== 1'b0 || ld_ready !== 1'b1 || wb_en !== 1'b0 || wb_dest !== dst)
          begin n_err++; $display("FAIL rnd_wait[%0d]: got mr %b lr %b en %b dest %0d want 0/1/0/%0d", i, mem_ready, ld_ready, wb_en, wb_dest, dst); end
        if (k == lat) begin ld_valid = 1'b1; ld_data = data; end
        step();
        ld_valid = 1'b0;
      end
      exp_count = exp_count + 32'd1;
      n_cmp++; if (wb_en !== wen || wb_dest !== dst || wb_value !== exp_val || retire_count !== exp_count)
        begin n_err++; $display("FAIL rnd_write[%0d]: got en %b dest %0d val %h count %0d want %b/%0d/%h/%0d",
                                i, wb_en, wb_dest, wb_value, retire_count, wen, dst, exp_val, exp_count); end
`ifdef WB_FORWARD_EN
      n_cmp++; if (fwd_valid !== wen || fwd_dest !== dst || fwd_value !== exp_val)
        begin n_err++; $display("FAIL rnd_fwd[%0d]: got %b/%0d/%h want %b/%0d/%h", i, fwd_valid, fwd_dest, fwd_value, wen, dst, exp_val); end
`endif
    end
    quiet();
    step();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_wait();
    test_load_same_cycle();
    test_no_wb_en();
    test_reset_mid_stream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
